// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// pc_unit : fetch-stage program counter with stall-buffered redirect and AdEL
// Revision: 1.0
// ============================================================================
module pc_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_3000),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(32'h0000_4180),
    parameter logic [WIDTH-1:0] IM_BASE  = WIDTH'(32'h0000_3000),
    parameter int unsigned      IM_WORDS = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             br_valid_i,
    input  logic [WIDTH-1:0] br_target_i,
    input  logic             exc_req_i,
    input  logic             eret_req_i,
    input  logic [WIDTH-1:0] epc_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus4_o,
    output logic             adel_o,
    output logic             redir_pend_o
);

    // Legal fetch window bounds, one bit wider so the top cannot overflow.
    localparam logic [WIDTH:0] c_IM_LO = {1'b0, IM_BASE};
    localparam logic [WIDTH:0] c_IM_HI = c_IM_LO + ((WIDTH+1)'(IM_WORDS) << 2);

    logic [WIDTH-1:0] pc_q = RESET_PC;
    logic [WIDTH-1:0] pc_d;
    logic             pend_valid_q = 1'b0;
    logic             pend_valid_d;
    logic [WIDTH-1:0] pend_target_q;
    logic [WIDTH-1:0] pend_target_d;

    logic [WIDTH-1:0] w_pc_plus4;
    logic             w_misaligned;
    logic             w_below;
    logic             w_above;

    assign w_pc_plus4 = pc_q + WIDTH'(4);

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (exc_req_i) begin
            pc_d         = EXC_PC;
            pend_valid_d = 1'b0;
        end else if (eret_req_i) begin
            pc_d         = epc_i;
            pend_valid_d = 1'b0;
        end else if (stall_i) begin
            // Hold fetch; remember only the newest redirect seen while stalled.
            if (br_valid_i) begin
                pend_valid_d  = 1'b1;
                pend_target_d = br_target_i;
            end
        end else if (br_valid_i) begin
            pc_d         = br_target_i;
            pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else begin
            pc_d = w_pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // Misaligned or out-of-window targets are loaded as-is and flagged here.
    assign w_misaligned = |pc_q[1:0];
    assign w_below      = ({1'b0, pc_q} < c_IM_LO);
    assign w_above      = ({1'b0, pc_q} >= c_IM_HI);

    assign pc_o         = pc_q;
    assign pc_plus4_o   = w_pc_plus4;
    assign adel_o       = w_misaligned | w_below | w_above;
    assign redir_pend_o = pend_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_unit : directed scenarios plus randomized run against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        br_valid_i;
    logic [31:0] br_target_i;
    logic        exc_req_i;
    logic        eret_req_i;
    logic [31:0] epc_i;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        adel_o;
    logic        redir_pend_o;

    logic        rst16;
    logic        zero1 = 1'b0;
    logic [15:0] zero16 = 16'h0000;
    logic [15:0] pc16_o;
    logic [15:0] pc16_plus4_o;
    logic        adel16_o;
    logic        pend16_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pend[$];

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_target_i(br_target_i), .exc_req_i(exc_req_i), .eret_req_i(eret_req_i),
        .epc_i(epc_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o), .adel_o(adel_o),
        .redir_pend_o(redir_pend_o)
    );

    pc_unit #(
        .WIDTH(16), .RESET_PC(16'hFFF8), .EXC_PC(16'h0180),
        .IM_BASE(16'h0000), .IM_WORDS(16384)
    ) dut16 (
        .clk(clk), .reset(rst16), .stall_i(zero1), .br_valid_i(zero1),
        .br_target_i(zero16), .exc_req_i(zero1), .eret_req_i(zero1),
        .epc_i(zero16), .pc_o(pc16_o), .pc_plus4_o(pc16_plus4_o), .adel_o(adel16_o),
        .redir_pend_o(pend16_o)
    );

    function automatic bit exp_adel(input logic [31:0] p);
        longint unsigned a = longint'(p);
        return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
    endfunction

    task automatic idle();
        reset = 0; stall_i = 0; br_valid_i = 0; br_target_i = 0;
        exc_req_i = 0; eret_req_i = 0; epc_i = 0;
    endtask

    // One clock edge; the reference model consumes the same inputs the DUT sees.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = 32'h3000; m_pend.delete();
        end else if (exc_req_i) begin
            m_pc = 32'h4180; m_pend.delete();
        end else if (eret_req_i) begin
            m_pc = epc_i; m_pend.delete();
        end else if (stall_i) begin
            if (br_valid_i) begin m_pend.delete(); m_pend.push_back(br_target_i); end
        end else if (br_valid_i) begin
            m_pc = br_target_i; m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
        end else begin
            m_pc = m_pc + 32'd4;
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; rst16 = 1;
        tick();
        reset = 0;
        total++; if (pc_o !== 32'h3000) begin bad++; $display("FAIL reset_pc got=%h want=3000", pc_o); end
        total++; if (pc_plus4_o !== 32'h3004) begin bad++; $display("FAIL reset_plus4 got=%h want=3004", pc_plus4_o); end
        total++; if (redir_pend_o !== 1'b0) begin bad++; $display("FAIL reset_pend got=%b want=0", redir_pend_o); end
        total++; if (adel_o !== 1'b0) begin bad++; $display("FAIL reset_adel got=%b want=0", adel_o); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (pc_o !== 32'h3000 + 32'(4 * i) || adel_o !== 1'b0) begin
                bad++; $display("FAIL seq_%0d got=%h/%b want=%h/0", i, pc_o, adel_o, 32'h3000 + 32'(4 * i));
            end
        end
        tick();
    endtask

    task automatic test_stall_redirect();
        stall_i = 1; br_valid_i = 1; br_target_i = 32'h3100;
        tick();
        total++; if (pc_o !== 32'h3010 || redir_pend_o !== 1'b1) begin bad++; $display("FAIL stall_first got=%h/%b want=3010/1", pc_o, redir_pend_o); end
        br_valid_i = 0;
        tick(); tick();
        total++; if (pc_o !== 32'h3010 || redir_pend_o !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%b want=3010/1", pc_o, redir_pend_o); end
        stall_i = 0;
        tick();
        total++; if (pc_o !== 32'h3100 || redir_pend_o !== 1'b0) begin bad++; $display("FAIL stall_release got=%h/%b want=3100/0", pc_o, redir_pend_o); end
        tick();
        total++; if (pc_o !== 32'h3104) begin bad++; $display("FAIL after_release got=%h want=3104", pc_o); end
    endtask

    task automatic test_live_beats_pending();
        stall_i = 1; br_valid_i = 1; br_target_i = 32'h3100;
        tick();
        stall_i = 0; br_target_i = 32'h3200;
        tick();
        br_valid_i = 0;
        total++; if (pc_o !== 32'h3200 || redir_pend_o !== 1'b0) begin bad++; $display("FAIL live_wins got=%h/%b want=3200/0", pc_o, redir_pend_o); end
    endtask

    task automatic test_exc_eret();
        stall_i = 1; br_valid_i = 1; br_target_i = 32'h3300;
        tick();
        br_valid_i = 0; exc_req_i = 1; eret_req_i = 1; epc_i = 32'h3008;
        tick();
        total++; if (pc_o !== 32'h4180 || redir_pend_o !== 1'b0) begin bad++; $display("FAIL exc_over_eret got=%h/%b want=4180/0", pc_o, redir_pend_o); end
        total++; if (adel_o !== 1'b0) begin bad++; $display("FAIL exc_adel got=%b want=0", adel_o); end
        exc_req_i = 0;
        tick();
        total++; if (pc_o !== 32'h3008) begin bad++; $display("FAIL eret got=%h want=3008", pc_o); end
        idle();
    endtask

    task automatic test_adel();
        logic [31:0] tgts [4] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC};
        logic        want [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            br_valid_i = 1; br_target_i = tgts[i];
            tick();
            total++;
            if (pc_o !== tgts[i] || adel_o !== want[i]) begin
                bad++; $display("FAIL adel_%h got=%h/%b want=%h/%b", tgts[i], pc_o, adel_o, tgts[i], want[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_pending();
        stall_i = 1; br_valid_i = 1; br_target_i = 32'h3400;
        tick();
        total++; if (redir_pend_o !== 1'b1) begin bad++; $display("FAIL rp_setup got=%b want=1", redir_pend_o); end
        br_valid_i = 0; reset = 1;
        tick();
        total++; if (pc_o !== 32'h3000 || redir_pend_o !== 1'b0) begin bad++; $display("FAIL rp_reset got=%h/%b want=3000/0", pc_o, redir_pend_o); end
        idle();
        tick();
        total++; if (pc_o !== 32'h3004) begin bad++; $display("FAIL rp_discard got=%h want=3004", pc_o); end
    endtask

    task automatic test_wrap();
        rst16 = 1;
        tick();
        rst16 = 0;
        total++; if (pc16_o !== 16'hFFF8 || adel16_o !== 1'b0) begin bad++; $display("FAIL wrap_reset got=%h/%b want=fff8/0", pc16_o, adel16_o); end
        tick();
        total++; if (pc16_o !== 16'hFFFC || pc16_plus4_o !== 16'h0000) begin bad++; $display("FAIL wrap_fffc got=%h/%h want=fffc/0000", pc16_o, pc16_plus4_o); end
        tick();
        total++; if (pc16_o !== 16'h0000 || adel16_o !== 1'b0 || pend16_o !== 1'b0) begin bad++; $display("FAIL wrap_zero got=%h/%b want=0000/0", pc16_o, adel16_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            reset      = ($urandom_range(0, 49) == 0);
            exc_req_i  = ($urandom_range(0, 19) == 0);
            eret_req_i = ($urandom_range(0, 19) == 0);
            stall_i    = ($urandom_range(0, 2) == 0);
            br_valid_i = ($urandom_range(0, 3) == 0);
            br_target_i = ($urandom_range(0, 3) == 0) ? $urandom()
                          : 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            epc_i      = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
            tick();
            total++;
            if (pc_o !== m_pc || pc_plus4_o !== m_pc + 32'd4 || adel_o !== exp_adel(m_pc)
                || redir_pend_o !== (m_pend.size() != 0)) begin
                bad++;
                $display("FAIL rand_%0d got=%h/%h/%b/%b want=%h/%h/%b/%b", n, pc_o, pc_plus4_o, adel_o,
                         redir_pend_o, m_pc, m_pc + 32'd4, exp_adel(m_pc), m_pend.size() != 0);
            end
        end
        idle();
    endtask

    initial begin
        idle(); rst16 = 1; m_pc = 32'h3000;
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_live_beats_pending();
        test_exc_eret();
        test_adel();
        test_reset_pending();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
